// File: rtl/uart_rx.sv
// uart_rx: 16x oversampled serial receiver for DBIT data bits, LSB first, and SB_TICK
// oversample ticks of stop bit. Defining UART_RX_PARITY_EN adds one even-parity bit
// after the data bits. Without it, parity_err is tied to 0.
`timescale 1ns / 1ps

module uart_rx #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_tick,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       frame_err,
    output logic       parity_err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic [4:0] S_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST = 3'(DBIT - 1);
    localparam int unsigned PAD   = 8 - DBIT;

    logic [2:0] state_q, state_d;
    logic [4:0] s_cnt_q, s_cnt_d;
    logic [2:0] n_cnt_q, n_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] dout_q, dout_d;
    logic       done_q, done_d;
    logic       frame_err_q, frame_err_d;
    logic [7:0] data_w;

    // Data bits enter at the MSB, so a short frame sits at the top of the shift register.
    assign data_w = shift_q >> PAD;

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    logic parity_err_q, parity_err_d;
`endif

    // Next-state logic for the receive FSM, counters and output registers
    always_comb begin
        state_d     = state_q;
        s_cnt_d     = s_cnt_q;
        n_cnt_d     = n_cnt_q;
        shift_d     = shift_q;
        dout_d      = dout_q;
        done_d      = 1'b0;
        frame_err_d = frame_err_q;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = parity_err_q;
`endif
        case (state_q)
            IDLE: begin
                // Leaving IDLE is the only transition not gated by s_tick.
                if (!rx) begin
                    state_d = START;
                    s_cnt_d = 5'd0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt_q == 5'd7) begin
                        if (!rx) begin
                            state_d = DATA;
                            s_cnt_d = 5'd0;
                            n_cnt_d = 3'd0;
                        end else begin
                            // Start bit not held to mid-bit: treat it as a glitch.
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt_q == 5'd15) begin
                        s_cnt_d = 5'd0;
                        shift_d = {rx, shift_q[7:1]};
                        if (n_cnt_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_cnt_d = n_cnt_q + 3'd1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 5'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_cnt_q == 5'd15) begin
                        par_d   = rx;
                        s_cnt_d = 5'd0;
                        state_d = STOP;
                    end else begin
                        s_cnt_d = s_cnt_q + 5'd1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_cnt_q == S_LAST) begin
                        dout_d      = data_w;
                        frame_err_d = ~rx;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = ^{data_w, par_q};
`endif
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_cnt_d = s_cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            s_cnt_q     <= 5'd0;
            n_cnt_q     <= 3'd0;
            shift_q     <= 8'd0;
            dout_q      <= 8'd0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            s_cnt_q     <= s_cnt_d;
            n_cnt_q     <= n_cnt_d;
            shift_q     <= shift_d;
            dout_q      <= dout_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames driven at 64 clks per bit with s_tick every 4 clks.
// A frame-level model (queue of expected byte/flags) is checked on every falling edge.
`timescale 1ns / 1ps

module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       s_tick;
    logic       rx = 1'b1;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
    logic       parity_err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] m_dout = 8'd0;
    logic       m_fe = 1'b0;
    logic       m_pe = 1'b0;
    logic       rst_at_edge = 1'b0;
    logic [1:0] tcnt = 2'd0;

    uart_rx dut (
        .clk          (clk),
        .rst          (rst),
        .s_tick       (s_tick),
        .rx           (rx),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .parity_err   (parity_err)
    );

    always #5 clk = ~clk;

    // Baud generator stand-in: one-clk tick every 4 clks.
    always @(posedge clk) tcnt <= tcnt + 2'd1;
    assign s_tick = (tcnt == 2'd3);

    always @(posedge clk) rst_at_edge <= rst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: outputs change only on a done pulse, to the next queued frame.
    always @(negedge clk) begin
        if (!rst_at_edge) begin
            m_dout = 8'd0;
            m_fe   = 1'b0;
            m_pe   = 1'b0;
            check("done_in_reset", rx_done_tick, 0);
        end else if (rx_done_tick) begin
            done_cnt++;
            check("done_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                m_dout = e.d;
                m_fe   = e.fe;
                m_pe   = e.pe;
            end
        end
        check("dout", dout, m_dout);
        check("frame_err", frame_err, m_fe);
        check("parity_err", parity_err, m_pe);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        step(n);
    endtask

    // A low stop bit is held for only 40 clks so the follow-on "start" is a rejected glitch.
    task automatic send(input logic [7:0] b, input logic stop_v, input logic par_v);
        exp_t e;
        e.d  = b;
        e.fe = ~stop_v;
`ifdef UART_RX_PARITY_EN
        e.pe = ^{b, par_v};
`else
        e.pe = 1'b0;
`endif
        exp_q.push_back(e);
        hold(1'b0, 64);
        for (int i = 0; i < 8; i++) hold(b[i], 64);
`ifdef UART_RX_PARITY_EN
        hold(par_v, 64);
`endif
        if (stop_v) begin
            hold(1'b1, 64);
        end else begin
            hold(1'b0, 40);
            hold(1'b1, 100);
        end
    endtask

    initial begin
        logic [7:0] ab;
        ab = 8'hC5;
        // Reset and idle
        rst = 1'b0;
        rx  = 1'b1;
        step(3);
        rst = 1'b1;
        step(200);
        check("idle_dout", dout, 8'h00);
        check("idle_done_cnt", done_cnt, 0);

        // Single bytes
        send(8'h55, 1'b1, ^8'h55);
        check("b55_dout", dout, 8'h55);
        check("b55_model", m_dout, 8'h55);
        check("b55_fe", frame_err, 0);
        check("b55_done_cnt", done_cnt, 1);
        hold(1'b1, 20);
        send(8'hA3, 1'b1, ^8'hA3);
        check("bA3_dout", dout, 8'hA3);
        check("bA3_done_cnt", done_cnt, 2);

        // Glitch start: 4 ticks low
        hold(1'b1, 20);
        hold(1'b0, 16);
        hold(1'b1, 80);
        check("glitch_done_cnt", done_cnt, 2);
        send(8'h3C, 1'b1, ^8'h3C);
        check("b3C_dout", dout, 8'h3C);
        check("b3C_done_cnt", done_cnt, 3);

        // Framing error, then a good frame clears it
        hold(1'b1, 20);
        send(8'hF0, 1'b0, ^8'hF0);
        check("bF0_dout", dout, 8'hF0);
        check("bF0_fe", frame_err, 1);
        check("bF0_model_fe", m_fe, 1);
        check("bF0_done_cnt", done_cnt, 4);
        send(8'h0F, 1'b1, ^8'h0F);
        check("b0F_dout", dout, 8'h0F);
        check("b0F_fe", frame_err, 0);

        // Reset during data bit 4 aborts the frame
        hold(1'b1, 20);
        hold(1'b0, 64);
        for (int i = 0; i < 4; i++) hold(ab[i], 64);
        hold(ab[4], 32);
        rst = 1'b0;
        rx  = 1'b1;
        step(3);
        rst = 1'b1;
        check("rst_dout", dout, 8'h00);
        check("rst_fe", frame_err, 0);
        hold(1'b1, 200);
        check("abort_done_cnt", done_cnt, 5);

        // Back-to-back frames with no idle gap
        send(8'h11, 1'b1, ^8'h11);
        check("b11_dout", dout, 8'h11);
        send(8'h22, 1'b1, ^8'h22);
        check("b22_dout", dout, 8'h22);
        send(8'h33, 1'b1, ^8'h33);
        check("b33_dout", dout, 8'h33);
        check("b2b_done_cnt", done_cnt, 8);

`ifdef UART_RX_PARITY_EN
        hold(1'b1, 20);
        send(8'h07, 1'b1, 1'b1);
        check("par_ok_pe", parity_err, 0);
        send(8'h07, 1'b1, 1'b0);
        check("par_bad_pe", parity_err, 1);
        check("par_bad_dout", dout, 8'h07);
`endif

        hold(1'b1, 50);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver, 16x oversampled.
- Sits directly downstream of the baud-rate tick generator. Its sampling enable `s_tick` is that generator's one-clock `tick` output, with the divisor set to clk/(16*baud) - 1.
- Recovers 8N1-style frames (optionally with parity) from the asynchronous `rx` line.
- Presents each received byte with a one-cycle done strobe and error flags.

Parameters:
- DBIT, 8: number of data bits per frame. Legal range 5..8. Sent LSB first.
- SB_TICK, 16: oversample ticks spent in the stop bit. 16, 24 or 32 give 1, 1.5 or 2 stop bits.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, synchronous, active-low. Asserted when 0 at a clk edge.
- s_tick  input  1  oversample enable, 1 clk wide, 16 per bit period.
- rx  input  1  serial line; idle high. The bench keeps it pre-synchronised.
- dout  output  8  last received byte. Bits above DBIT-1 are 0.
- rx_done_tick  output  1  one-clk pulse when a frame completes.
- frame_err  output  1  stop bit sampled low on the last frame.
- parity_err  output  1  parity mismatch on the last frame. Tied 0 without PARITY_EN.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE; s_cnt=0, n_cnt=0, shift reg=0.
  - dout=0, rx_done_tick=0, frame_err=0, parity_err=0.
  - Reset mid-frame aborts the frame with no done pulse. Reception restarts on the next falling edge after release.
- Counters:
  - s_cnt is 5 bits; it counts s_tick within a bit.
  - n_cnt is 3 bits; it is the data-bit index.
  - All counter updates happen only on clk edges where s_tick=1, except the IDLE exit.
- States:
  - IDLE: rx==0 at a clk edge (s_tick is ignored) -> START, s_cnt=0.
  - START:
    - On s_tick with s_cnt==7 (mid start bit): rx==0 -> DATA, s_cnt=0, n_cnt=0.
    - rx==1 -> IDLE; this is glitch rejection, with no strobe and no flag change.
    - Otherwise s_cnt+1.
  - DATA:
    - On s_tick with s_cnt==15: s_cnt=0 and shift_reg={rx, shift_reg[7:1]}.
    - Then, if n_cnt==DBIT-1, go to PARITY (with PARITY_EN) or STOP; otherwise n_cnt+1.
    - Otherwise s_cnt+1.
  - PARITY (PARITY_EN only): on s_tick with s_cnt==15, latch the sampled parity bit, s_cnt=0, -> STOP.
  - STOP:
    - On s_tick with s_cnt==SB_TICK-1, the following occur on the same edge:
      - dout <= shift_reg >> (8-DBIT);
      - frame_err <= ~rx;
      - parity_err <= computed mismatch;
      - rx_done_tick=1 for exactly that one clk;
      - -> IDLE.
    - Otherwise s_cnt+1.
- Output latency: dout and the flags are valid in the same cycle as rx_done_tick, and hold until the next done.
- A frame with frame_err=1 still delivers dout and the done pulse.
- If rx is low on the cycle after STOP->IDLE (a break, or an immediate next start bit), IDLE->START is taken at once. Back-to-back frames with zero idle are supported.
- s_tick during IDLE has no effect.
- s_tick held high continuously is legal; each clk then counts as one tick.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - The PARITY state is present; one parity bit follows the data bits.
  - Parity is even: parity_err = ^{data bits, parity bit}.
- Undefined:
  - No PARITY state; DATA goes straight to STOP.
  - parity_err is driven constant 0.
  - Frame length is 1+DBIT+stop.

Test Plan:
- Reset and idle:
  - Stimulus: rst=0 for 3 clks, then rx=1 and s_tick every 4 clks for 200 clks.
  - Required: dout=0x00, all strobes and flags 0, no done.
- Single byte 0x55:
  - Stimulus: default parameters, s_tick every 4 clks, rx frame 0,1,0,1,0,1,0,1,0,1 at 64 clks per bit.
  - Required: exactly one rx_done_tick with dout=0x55 and frame_err=0.
  - Then 0xA3 -> dout=0xA3.
- Glitch start:
  - Stimulus: rx low for 4 ticks, then high.
  - Required: no rx_done_tick; state returns to IDLE. A valid 0x3C sent afterwards is received correctly.
- Framing error:
  - Stimulus: send 0xF0 with the stop bit driven 0.
  - Required: rx_done_tick with dout=0xF0 and frame_err=1.
  - The next good frame 0x0F clears frame_err to 0.
- Reset mid-frame and back-to-back:
  - Stimulus: assert rst during data bit 4, then release; next send 0x11, 0x22, 0x33 with no idle gap.
  - Required: no done from the aborted frame; three done pulses with 0x11, 0x22, 0x33 in order.
- Parity (UART_RX_PARITY_EN defined):
  - Stimulus: send 0x07 with parity bit 1.
  - Required: parity_err=0.
  - The same frame with parity bit 0 gives parity_err=1 and dout=0x07.
